// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// ------------------
// Shares the single register-file write port between the ALU writeback
// requester (A) and the load/memory writeback requester (M) with round-robin
// arbitration. The winning write is registered so it is stable across the
// register file's negedge write. A per-register busy scoreboard tracks
// reserved destinations and produces the decode read-hazard stall.
//
// Handshake: a requester raises *_valid with stable addr/data and keeps them
// stable until it sees *_ready high in the same cycle; valid & ready at a
// posedge is one transfer. *_ready never depends on anything but the valids
// and the round-robin state, so a requester may wait on it combinationally.
//
// Optional build macro: R0_HARDWIRED_EN
//   defined   - register 0 is constant: writes to r0 are accepted but never
//               strobe rf_write, and busy[0] is held at 0.
//   undefined - register 0 behaves like any other register.
//
// Ports:
//   clk, reset (async, active-low)
//   a_valid/a_addr/a_data/a_ready   ALU writeback request
//   m_valid/m_addr/m_data/m_ready   memory writeback request
//   issue_valid/issue_reg/issue_ready  destination reservation
//   rs1/rs2/rs1_chk/rs2_chk         decode source operands
//   flush                           synchronous scoreboard clear
//   rf_write/rf_addr/rf_data        registered register-file write port
//   stall                           read hazard
//   busy                            scoreboard vector (one bit per register)
//   idle                            no reservations outstanding
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int START_PRIO = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_valid,
  input  logic [ADDR_W-1:0]        a_addr,
  input  logic [DATA_W-1:0]        a_data,
  output logic                     a_ready,
  input  logic                     m_valid,
  input  logic [ADDR_W-1:0]        m_addr,
  input  logic [DATA_W-1:0]        m_data,
  output logic                     m_ready,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_reg,
  output logic                     issue_ready,
  input  logic [ADDR_W-1:0]        rs1,
  input  logic [ADDR_W-1:0]        rs2,
  input  logic                     rs1_chk,
  input  logic                     rs2_chk,
  input  logic                     flush,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic [DATA_W-1:0]        rf_data,
  output logic                     stall,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     idle
);

  localparam int NREG = 1 << ADDR_W;
  // rr_last encoding: 0 = A was granted last, 1 = M was granted last.
  // Resetting it to the opposite of START_PRIO makes START_PRIO win first.
  localparam logic RR_RESET = (START_PRIO == 0) ? 1'b1 : 1'b0;

  logic              rr_last_q, rr_last_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic              grant_a, grant_m, transfer, win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Arbitration and write-stage next state.
  always_comb begin
    grant_a   = a_valid & (~m_valid | rr_last_q);
    grant_m   = m_valid & (~a_valid | ~rr_last_q);
    transfer  = grant_a | grant_m;
    win_addr  = grant_m ? m_addr : a_addr;
    win_data  = grant_m ? m_data : a_data;
    rr_last_d = transfer ? grant_m : rr_last_q;
`ifdef R0_HARDWIRED_EN
    // Writes to r0 are consumed but never reach the register file.
    win_wr    = transfer & (win_addr != '0);
`else
    win_wr    = transfer;
`endif
    rf_write_d = win_wr;
    rf_addr_d  = win_wr ? win_addr : rf_addr_q;
    rf_data_d  = win_wr ? win_data : rf_data_q;
  end

  // Scoreboard next state. Order matters: clear from the completing write,
  // then set from a new reservation (set wins), then flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (rf_write_q) busy_d[rf_addr_q] = 1'b0;
    if (issue_valid && issue_ready) busy_d[issue_reg] = 1'b1;
    if (flush) busy_d = '0;
`ifdef R0_HARDWIRED_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q  <= RR_RESET;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      busy_q     <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
      busy_q     <= busy_d;
    end
  end

  assign a_ready     = grant_a;
  assign m_ready     = grant_m;
  assign issue_ready = ~busy_q[issue_reg];
  assign stall       = (rs1_chk & busy_q[rs1]) | (rs2_chk & busy_q[rs2]);
  assign idle        = ~|busy_q;
  assign rf_write    = rf_write_q;
  assign rf_addr     = rf_addr_q;
  assign rf_data     = rf_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed steps from the test plan followed
// by randomized traffic, all checked against a behavioural reference model.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;
`ifdef R0_HARDWIRED_EN
  localparam bit R0HW = 1'b1;
`else
  localparam bit R0HW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, m_valid, issue_valid, rs1_chk, rs2_chk, flush;
  logic [AW-1:0] a_addr, m_addr, issue_reg, rs1, rs2;
  logic [DW-1:0] a_data, m_data;
  logic          a_ready, m_ready, issue_ready, rf_write, stall, idle;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [NR-1:0] busy;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .START_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_chk(rs1_chk), .rs2_chk(rs2_chk), .flush(flush),
    .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
    .stall(stall), .busy(busy), .idle(idle)
  );

  // clock / reset
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference model
  bit                 ref_busy [NR];
  bit                 ref_m_last;          // 1 = M was granted last
  logic [AW+DW-1:0]   exp_q [$];           // write expected on the next edge
  logic [AW-1:0]      hold_addr;
  logic [DW-1:0]      hold_data;

  // comb outputs captured at the last negedge
  logic o_a_ready, o_m_ready, o_issue_ready, o_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] ref_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = ref_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ref_busy[i] = 1'b0;
    ref_m_last = 1'b1;  // START_PRIO = 0: A wins the first contest
    exp_q.delete();
    hold_addr = '0;
    hold_data = '0;
  endtask

  task automatic idle_inputs();
    a_valid = 0; m_valid = 0; issue_valid = 0; flush = 0;
    rs1_chk = 0; rs2_chk = 0;
    a_addr = '0; m_addr = '0; issue_reg = '0; rs1 = '0; rs2 = '0;
    a_data = '0; m_data = '0;
  endtask

  // One clock: combinational checks at negedge, model step at posedge,
  // registered checks just after the posedge.
  task automatic cycle();
    logic ea, em, e_ir, e_st, pend;
    logic [AW+DW-1:0] pw;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    @(negedge clk);
    ea   = a_valid && (!m_valid || ref_m_last);
    em   = m_valid && (!a_valid || !ref_m_last);
    e_ir = !ref_busy[issue_reg];
    e_st = (rs1_chk && ref_busy[rs1]) || (rs2_chk && ref_busy[rs2]);
    o_a_ready = a_ready; o_m_ready = m_ready;
    o_issue_ready = issue_ready; o_stall = stall;
    check("a_ready", a_ready, ea);
    check("m_ready", m_ready, em);
    check("issue_ready", issue_ready, e_ir);
    check("stall", stall, e_st);
    pend = (exp_q.size() > 0);
    pw   = pend ? exp_q.pop_front() : '0;
    @(posedge clk);
    #1;
    if (pend) ref_busy[pw[AW+DW-1:DW]] = 1'b0;
    if (issue_valid && e_ir) ref_busy[issue_reg] = 1'b1;
    if (flush) for (int i = 0; i < NR; i++) ref_busy[i] = 1'b0;
    if (R0HW) ref_busy[0] = 1'b0;
    if (ea || em) begin
      waddr = em ? m_addr : a_addr;
      wdata = em ? m_data : a_data;
      ref_m_last = em;
      if (!(R0HW && waddr == '0)) begin
        exp_q.push_back({waddr, wdata});
        hold_addr = waddr;
        hold_data = wdata;
      end
    end
    check("rf_write", rf_write, exp_q.size() > 0);
    check("rf_addr", rf_addr, hold_addr);
    check("rf_data", rf_data, hold_data);
    check("busy", busy, ref_busy_vec());
    check("idle", idle, ref_busy_vec() == '0);
  endtask

  logic [DW-1:0] rr_data [4];

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #12;
    check("reset_rf_write", rf_write, 1'b0);
    check("reset_rf_addr", rf_addr, '0);
    check("reset_rf_data", rf_data, '0);
    check("reset_busy", busy, '0);
    check("reset_idle", idle, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // round-robin: A, M, A, M with the loser holding its request
    rr_data[0] = 32'h1111_0000; rr_data[1] = 32'h2222_0001;
    rr_data[2] = 32'h3333_0002; rr_data[3] = 32'h4444_0003;
    a_valid = 1; a_addr = 5'd1; a_data = rr_data[0];
    m_valid = 1; m_addr = 5'd2; m_data = rr_data[1];
    cycle();
    check("rr_grant0_a", o_a_ready, 1'b1);
    check("rr_data0", rf_data, rr_data[0]);
    a_addr = 5'd3; a_data = rr_data[2];
    cycle();
    check("rr_grant1_m", o_m_ready, 1'b1);
    check("rr_data1", rf_data, rr_data[1]);
    m_addr = 5'd4; m_data = rr_data[3];
    cycle();
    check("rr_grant2_a", o_a_ready, 1'b1);
    check("rr_data2", rf_data, rr_data[2]);
    a_valid = 0;
    cycle();
    check("rr_grant3_m", o_m_ready, 1'b1);
    check("rr_data3", rf_data, rr_data[3]);
    check("rr_write_cont", rf_write, 1'b1);
    m_valid = 0;

    // single request
    cycle();
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    cycle();
    check("single_ready", o_a_ready, 1'b1);
    check("single_write", rf_write, 1'b1);
    check("single_addr", rf_addr, 5'd5);
    check("single_data", rf_data, 32'hDEADBEEF);
    a_valid = 0;
    cycle();
    check("single_write_drop", rf_write, 1'b0);

    // hazard on r7
    issue_valid = 1; issue_reg = 5'd7;
    cycle();
    check("haz_busy7", busy[7], 1'b1);
    rs1 = 5'd7; rs1_chk = 1;
    cycle();
    check("haz_stall", o_stall, 1'b1);
    check("haz_issue_blocked", o_issue_ready, 1'b0);
    issue_valid = 0;
    m_valid = 1; m_addr = 5'd7; m_data = 32'h0BAD_F00D;
    cycle();
    m_valid = 0;
    check("haz_wb_strobe", rf_write, 1'b1);
    check("haz_still_busy", busy[7], 1'b1);
    cycle();
    check("haz_busy7_clear", busy[7], 1'b0);
    check("haz_stall_clear", stall, 1'b0);
    rs1_chk = 0;

    // set/clear collision on r9
    m_valid = 1; m_addr = 5'd9; m_data = 32'h9999_9999;
    cycle();
    m_valid = 0;
    issue_valid = 1; issue_reg = 5'd9;
    cycle();
    check("collide_busy9", busy[9], 1'b1);
    issue_reg = 5'd8;  cycle();
    issue_reg = 5'd10; cycle();
    issue_reg = 5'd11; cycle();
    check("flush_pre_busy", busy, 32'h0000_0F00);
    flush = 1; issue_reg = 5'd3;
    cycle();
    check("flush_busy", busy, '0);
    check("flush_idle", idle, 1'b1);
    flush = 0; issue_valid = 0;

    // register 0
    a_valid = 1; a_addr = 5'd0; a_data = 32'hA5A5_0000;
    cycle();
    a_valid = 0;
    check("r0_ready", o_a_ready, 1'b1);
    check("r0_write", rf_write, !R0HW);
    issue_valid = 1; issue_reg = 5'd0;
    cycle();
    issue_valid = 0;
    check("r0_busy", busy[0], !R0HW);
    rs1 = 5'd0; rs1_chk = 1;
    #1;
    check("r0_stall", stall, !R0HW);
    rs1_chk = 0;
    cycle();

    // reset while a write is pending
    a_valid = 1; a_addr = 5'd12; a_data = 32'hCAFE_1234;
    cycle();
    check("rst_pre_write", rf_write, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_write", rf_write, 1'b0);
    check("rst_mid_addr", rf_addr, '0);
    check("rst_mid_data", rf_data, '0);
    check("rst_mid_busy", busy, '0);
    check("rst_mid_idle", idle, 1'b1);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!(a_valid && !o_a_ready)) begin
        a_valid = ($urandom_range(0, 2) != 0);
        a_addr  = AW'($urandom_range(0, NR-1));
        a_data  = $urandom;
      end
      if (!(m_valid && !o_m_ready)) begin
        m_valid = ($urandom_range(0, 2) != 0);
        m_addr  = AW'($urandom_range(0, NR-1));
        m_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_reg   = AW'($urandom_range(0, NR-1));
      rs1 = AW'($urandom_range(0, NR-1));
      rs2 = AW'($urandom_range(0, NR-1));
      rs1_chk = $urandom_range(0, 1) != 0;
      rs2_chk = $urandom_range(0, 1) != 0;
      flush   = ($urandom_range(0, 24) == 0);
      o_a_ready = 1'b1; o_m_ready = 1'b1;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
